pipeline_stall_controller: RTL

Central stall/flush sequencer for the 5-stage pipeline. Merges three event sources into one consistent set of pipeline-register enables:
- load-use hazard indication from the ID-stage hazard detection logic;
- branch-taken from ID;
- a multi-cycle data-memory handshake from MEM.

It also gates pipeline start-up, issues single-pulse memory requests, and halts the core on a memory timeout. Sits between the ID/MEM control signals and the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register enables.

---
 rtl/pipeline_stall_controller.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central stall/flush sequencer for the 5-stage pipeline. Combines the ID
// load-use hazard, the ID branch-taken indication and the MEM data-memory
// handshake into one consistent set of pipeline-register enables. It also
// gates pipeline start-up, issues a single-cycle memory request pulse and
// halts the core when a memory access times out.
//
// Parameters:
//   MEM_TIMEOUT : max MEM_WAIT cycles without ack before HALT (0 = never)
//   CNT_W       : width of each performance counter
//
// Optional feature:
//   PIPE_PERF_CNT_EN : when defined, builds saturating stall / flush /
//                      memory-freeze counters; otherwise the counter outputs
//                      are tied to zero and no counter flops exist.
//
// Ports:
//   clk_i          in   clock, rising edge
//   rst_i          in   asynchronous active-high reset
//   start_i        in   level, pipeline runs while high
//   load_use_i     in   load-use hazard detected in ID
//   branch_taken_i in   branch in ID resolved taken
//   mem_req_i      in   instruction in MEM is a load or store
//   mem_ack_i      in   data memory completed the access
//   pc_write_o     out  PC update enable
//   if_id_write_o  out  IF/ID write enable
//   if_id_flush_o  out  clear IF/ID to NOP
//   id_ex_nop_o    out  insert bubble into ID/EX
//   pipe_freeze_o  out  hold ID/EX, EX/MEM and MEM/WB
//   mem_start_o    out  one-cycle request pulse to data memory
//   mem_err_o      out  sticky timeout error (held until reset)
//   stall_cnt_o    out  load-use bubble count
//   flush_cnt_o    out  flush count
//   memwait_cnt_o  out  memory-freeze cycle count
//
// All pipeline control outputs are combinational from state and inputs so
// that a same-cycle ack costs no stall cycle.
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_nop_o,
  output logic             pipe_freeze_o,
  output logic             mem_start_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] memwait_cnt_o
);

  // Wait counter wide enough to hold MEM_TIMEOUT, never narrower than 1 bit.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;

  logic memstall_c;
  logic timeout_hit_c;
  logic flow_pc_c;
  logic flow_ifw_c;
  logic flow_flush_c;
  logic flow_nop_c;

  // Outstanding access in MEM that the memory has not yet acknowledged.
  assign memstall_c = mem_req_i & ~mem_ack_i;

  // True on the MEM_TIMEOUT-th MEM_WAIT cycle (counter still holds k-1).
  assign timeout_hit_c = (MEM_TIMEOUT != 0) &&
                         ((32'(wait_cnt) + 32'd1) == 32'(MEM_TIMEOUT));

  // Front-end flow control once the memory is not stalling: load-use beats
  // branch, so a branch under a load-use bubble is re-evaluated next cycle.
  always_comb begin
    flow_pc_c    = 1'b1;
    flow_ifw_c   = 1'b1;
    flow_flush_c = 1'b0;
    flow_nop_c   = 1'b0;
    if (load_use_i) begin
      flow_pc_c  = 1'b0;
      flow_ifw_c = 1'b0;
      flow_nop_c = 1'b1;
    end else if (branch_taken_i) begin
      flow_flush_c = 1'b1;
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state and wait-counter update.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_IDLE: begin
        if (start_i) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (memstall_c) begin
          state_nxt    = S_MEM_WAIT;
          wait_cnt_nxt = '0;
        end else if (!start_i) begin
          state_nxt = S_IDLE;
        end
      end
      S_MEM_WAIT: begin
        // start_i is deliberately ignored until the access completes.
        if (mem_ack_i) begin
          state_nxt = S_RUN;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          if (timeout_hit_c) state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode; defaults hold the pipeline frozen with no PC update.
  always_comb begin
    pc_write_o    = 1'b0;
    if_id_write_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_nop_o   = 1'b0;
    pipe_freeze_o = 1'b1;
    mem_start_o   = 1'b0;
    mem_err_o     = 1'b0;
    case (state)
      S_RUN: begin
        // Request pulse is issued even when the ack arrives in the same cycle.
        mem_start_o = mem_req_i;
        if (!memstall_c) begin
          pc_write_o    = flow_pc_c;
          if_id_write_o = flow_ifw_c;
          if_id_flush_o = flow_flush_c;
          id_ex_nop_o   = flow_nop_c;
          pipe_freeze_o = 1'b0;
        end
      end
      S_MEM_WAIT: begin
        // The ack cycle itself is not frozen; normal flow rules apply.
        if (mem_ack_i) begin
          pc_write_o    = flow_pc_c;
          if_id_write_o = flow_ifw_c;
          if_id_flush_o = flow_flush_c;
          id_ex_nop_o   = flow_nop_c;
          pipe_freeze_o = 1'b0;
        end
      end
      S_HALT: begin
        mem_err_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef PIPE_PERF_CNT_EN
  logic             memwait_inc_c;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] memwait_cnt;

  // Memory-freeze cycles: RUN memstall cycles and unacknowledged wait cycles.
  assign memwait_inc_c = ((state == S_RUN) && memstall_c) ||
                         ((state == S_MEM_WAIT) && !mem_ack_i);

  // Saturating performance counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if (id_ex_nop_o && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush_o && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (memwait_inc_c && (memwait_cnt != '1))
        memwait_cnt <= memwait_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o   = stall_cnt;
  assign flush_cnt_o   = flush_cnt;
  assign memwait_cnt_o = memwait_cnt;
`else
  assign stall_cnt_o   = '0;
  assign flush_cnt_o   = '0;
  assign memwait_cnt_o = '0;
`endif

endmodule
